mux_n1_pipe: RTL and testbench
==============================

Name: mux_n1_pipe

Overview:
- Parametrised registered N:1 multiplexer, successor to the fixed 6-input datapath mux.
- Selects one of NUM_ENTRADAS data words using a binary index and registers the result.
- Uses valid/ready handshakes on input and output, with a one-entry skid buffer so it sustains full throughput under backpressure.
- Sits between datapath source registers and the next pipeline stage; flags out-of-range selector codes instead of holding stale data.

Parameters:
- NUM_ENTRADAS, 6, number of data inputs (2..64).
- LARGURA, 32, data width in bits.
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= NUM_ENTRADAS (elaboration-time check).
- CNT_W, 16, width of the optional error counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- entradas  in  NUM_ENTRADAS*LARGURA  flat input bus; entry i = entradas[i*LARGURA +: LARGURA], entry 0 in the LSBs
- seletor  in  SEL_W  binary index of the entry to select
- entrada_valida  in  1  upstream beat valid
- entrada_pronta  out  1  block can accept a beat
- saida  out  LARGURA  registered selected word
- saida_valida  out  1  saida/saida_erro hold a beat
- saida_pronta  in  1  downstream accepts the beat
- saida_erro  out  1  beat was captured with seletor >= NUM_ENTRADAS

Behaviour:
- Transfers:
  - accept = entrada_valida & entrada_pronta.
  - consume = saida_valida & saida_pronta.
- Selection (combinational, input side):
  - If seletor < NUM_ENTRADAS: data = selected entry, erro = 0.
  - Otherwise: data = 0, erro = 1.
  - Data and erro travel together as one beat.
- FSM states: VAZIO, CHEIO, SKID.
  - Registers: main (data+erro, drives saida/saida_erro) and skid (data+erro).
  - entrada_pronta = (state != SKID), decoded from the state register only; no combinational path from saida_pronta.
  - saida_valida = (state != VAZIO).
- Transitions:
  - VAZIO: accept -> load main, go to CHEIO.
  - CHEIO, accept & consume -> load main, stay in CHEIO.
  - CHEIO, accept & !consume -> load skid, go to SKID; main unchanged.
  - CHEIO, !accept & consume -> go to VAZIO.
  - CHEIO, neither -> hold.
  - SKID: consume -> main <= skid, go to CHEIO; no accept possible in SKID.
- Latency: a beat accepted at edge k appears on saida with saida_valida = 1 after edge k (1 cycle).
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Stability: while saida_valida & !saida_pronta, saida and saida_erro are held constant.
- Reset (asynchronous, any time, including mid-transfer):
  - state = VAZIO; main and skid = 0.
  - saida = 0, saida_erro = 0, saida_valida = 0, entrada_pronta = 1 while reset is asserted and after release.
  - In-flight beats are discarded.
- Inputs are sampled only on accept. Changes to seletor or entradas outside an accept have no effect.
- NUM_ENTRADAS not a power of two: unused codes always take the error path. NUM_ENTRADAS = 2**SEL_W: the error path is unreachable and saida_erro stays 0.

Optional Feature:
- Macro: MUX_CONTADOR_ERRO_EN.
- Defined:
  - Adds output contador_erro [CNT_W-1:0] and input limpa_contador (1).
  - The counter increments on each accept with an out-of-range seletor and saturates at all-ones.
  - limpa_contador clears it synchronously; clear wins over a simultaneous increment (result 0).
  - Reset value 0.
- Undefined: both ports and the counter are absent. saida_erro behaviour is identical in both builds.

Decomposition:
- Shared package mux_pkg:
  - State encodings VAZIO=2'b00, CHEIO=2'b01, SKID=2'b10.
  - clog2 helper function used for the SEL_W check.
  - Beat struct/width constant (LARGURA+1).
- Sub-module mux_sel_comb, purely combinational: entradas + seletor -> data, erro. Instantiated once ahead of the registers.

Test Plan:
- Reset mid-transfer: assert reset in SKID with both registers full -> saida_valida=0, entrada_pronta=1, saida=0 immediately; next beat accepted normally.
- Streaming: NUM_ENTRADAS=6, LARGURA=32, entries i -> 32'hA0+i, saida_pronta=1, seletor 0..5 on consecutive cycles -> saida 32'hA0..32'hA5 one cycle later, one beat per cycle, saida_erro=0.
- Out-of-range selector: seletor=6 and seletor=7 -> saida=0, saida_erro=1 on those beats; with MUX_CONTADOR_ERRO_EN defined, contador_erro=2.
- Backpressure: hold saida_pronta=0 and offer beats with seletor=1 then seletor=2:
  - After 2 accepts, entrada_pronta=0 and saida stays 32'hA1.
  - Release -> 32'hA1 then 32'hA2, no loss.
- Simultaneous events: in CHEIO, accept and consume on the same edge -> state stays CHEIO with the new value; with the option defined, limpa_contador on the same edge as an error increment -> counter 0.
- Counter saturation: with the option defined and CNT_W=4, 20 error beats -> contador_erro=4'hF.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer: FSM encodings and
// width helpers used for the beat registers and the selector width check.
package mux_pkg;

  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    CHEIO = 2'b01,
    SKID  = 2'b10
  } estado_t;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned valor);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(valor)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // A beat is the data word plus its error flag in the MSB.
  function automatic int unsigned beat_w(input int unsigned largura);
    return largura + 1;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational selector: picks entry seletor from the flat bus, or flags an
// out-of-range code with zero data.
module mux_sel_comb #(
  parameter int unsigned NUM_ENTRADAS = 6,
  parameter int unsigned LARGURA      = 32,
  parameter int unsigned SEL_W        = 3
) (
  input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
  input  logic [SEL_W-1:0]                seletor,
  output logic [LARGURA-1:0]              dado_c,
  output logic                            erro_c
);

  always_comb begin
    dado_c = '0;
    erro_c = 1'b1;
    for (int i = 0; i < int'(NUM_ENTRADAS); i++) begin
      if (seletor == SEL_W'(i)) begin
        dado_c = entradas[i*LARGURA +: LARGURA];
        erro_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n1_pipe.sv
// Registered N:1 mux with valid/ready handshakes and a one-entry skid buffer.
// Optional saturating error counter enabled by MUX_CONTADOR_ERRO_EN.
module mux_n1_pipe
  import mux_pkg::*;
#(
  parameter int unsigned NUM_ENTRADAS = 6,
  parameter int unsigned LARGURA      = 32,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                            clock,
  input  logic                            reset,
`ifdef MUX_CONTADOR_ERRO_EN
  input  logic                            limpa_contador,
  output logic [CNT_W-1:0]                contador_erro,
`endif
  input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
  input  logic [SEL_W-1:0]                seletor,
  input  logic                            entrada_valida,
  output logic                            entrada_pronta,
  output logic [LARGURA-1:0]              saida,
  output logic                            saida_valida,
  input  logic                            saida_pronta,
  output logic                            saida_erro
);

  localparam int unsigned BEAT_W = beat_w(LARGURA);

  if (SEL_W < clog2(NUM_ENTRADAS) || NUM_ENTRADAS < 2 || NUM_ENTRADAS > 64 ||
      CNT_W < 1) begin : g_param_invalido
    $error("mux_n1_pipe: invalid NUM_ENTRADAS/SEL_W/CNT_W combination");
  end

  logic [LARGURA-1:0] sel_dado_c;
  logic               sel_erro_c;
  logic [BEAT_W-1:0]  beat_c;
  logic [BEAT_W-1:0]  principal;
  logic [BEAT_W-1:0]  skid;
  estado_t            estado;
  logic               aceita_c;
  logic               consome_c;

  mux_sel_comb #(
    .NUM_ENTRADAS(NUM_ENTRADAS),
    .LARGURA     (LARGURA),
    .SEL_W       (SEL_W)
  ) u_sel (
    .entradas(entradas),
    .seletor (seletor),
    .dado_c  (sel_dado_c),
    .erro_c  (sel_erro_c)
  );

  assign beat_c    = {sel_erro_c, sel_dado_c};
  assign aceita_c  = entrada_valida & entrada_pronta;
  assign consome_c = saida_valida & saida_pronta;

  // Handshake flags are flopped alongside the state so neither output
  // depends combinationally on the downstream ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= VAZIO;
      principal      <= '0;
      skid           <= '0;
      entrada_pronta <= 1'b1;
      saida_valida   <= 1'b0;
    end else begin
      case (estado)
        VAZIO: begin
          if (aceita_c) begin
            principal    <= beat_c;
            estado       <= CHEIO;
            saida_valida <= 1'b1;
          end
        end
        CHEIO: begin
          if (aceita_c && consome_c) begin
            principal <= beat_c;
          end else if (aceita_c) begin
            skid           <= beat_c;
            estado         <= SKID;
            entrada_pronta <= 1'b0;
          end else if (consome_c) begin
            estado       <= VAZIO;
            saida_valida <= 1'b0;
          end
        end
        SKID: begin
          if (consome_c) begin
            principal      <= skid;
            estado         <= CHEIO;
            entrada_pronta <= 1'b1;
          end
        end
        default: begin
          estado         <= VAZIO;
          entrada_pronta <= 1'b1;
          saida_valida   <= 1'b0;
        end
      endcase
    end
  end

  assign saida      = principal[LARGURA-1:0];
  assign saida_erro = principal[LARGURA];

`ifdef MUX_CONTADOR_ERRO_EN
  // Saturating count of accepted out-of-range beats; clear has priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_erro <= '0;
    end else if (limpa_contador) begin
      contador_erro <= '0;
    end else if (aceita_c && sel_erro_c && (contador_erro != '1)) begin
      contador_erro <= contador_erro + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Self-checking bench for mux_n1_pipe: table-driven streaming vectors plus
// directed backpressure, simultaneous-event and reset sequences.
module tb_mux_n1_pipe;

  localparam int unsigned N  = 6;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 4;

  logic             clock;
  logic             reset;
  logic [N*W-1:0]   entradas;
  logic [SW-1:0]    seletor;
  logic             entrada_valida;
  logic             entrada_pronta;
  logic [W-1:0]     saida;
  logic             saida_valida;
  logic             saida_pronta;
  logic             saida_erro;
`ifdef MUX_CONTADOR_ERRO_EN
  logic             limpa_contador;
  logic [CW-1:0]    contador_erro;
`endif

  int n_testes;
  int n_falhas;

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  exp_dado;
    logic          exp_erro;
  } vetor_t;

  vetor_t vetores[8];

  mux_n1_pipe #(
    .NUM_ENTRADAS(N),
    .LARGURA     (W),
    .SEL_W       (SW),
    .CNT_W       (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
`ifdef MUX_CONTADOR_ERRO_EN
    .limpa_contador(limpa_contador),
    .contador_erro (contador_erro),
`endif
    .entradas      (entradas),
    .seletor       (seletor),
    .entrada_valida(entrada_valida),
    .entrada_pronta(entrada_pronta),
    .saida         (saida),
    .saida_valida  (saida_valida),
    .saida_pronta  (saida_pronta),
    .saida_erro    (saida_erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input logic [W-1:0] obtido,
                       input logic [W-1:0] esperado);
    n_testes++;
    if (obtido !== esperado) begin
      n_falhas++;
      $display("FAIL %s: got %0h, expected %0h", nome, obtido, esperado);
    end
  endtask

  initial begin
    n_testes = 0;
    n_falhas = 0;
    vetores[0] = '{3'd0, 32'hA0, 1'b0};
    vetores[1] = '{3'd1, 32'hA1, 1'b0};
    vetores[2] = '{3'd2, 32'hA2, 1'b0};
    vetores[3] = '{3'd3, 32'hA3, 1'b0};
    vetores[4] = '{3'd4, 32'hA4, 1'b0};
    vetores[5] = '{3'd5, 32'hA5, 1'b0};
    vetores[6] = '{3'd6, 32'h00, 1'b1};
    vetores[7] = '{3'd7, 32'h00, 1'b1};

    for (int i = 0; i < int'(N); i++) entradas[i*W +: W] = 32'hA0 + 32'(i);
    reset          = 1'b1;
    seletor        = '0;
    entrada_valida = 1'b0;
    saida_pronta   = 1'b0;
`ifdef MUX_CONTADOR_ERRO_EN
    limpa_contador = 1'b0;
`endif
    tick();
    tick();
    check("reset_valida", 32'(saida_valida), 32'd0);
    check("reset_pronta", 32'(entrada_pronta), 32'd1);
    check("reset_saida", saida, 32'h0);
    check("reset_erro", 32'(saida_erro), 32'd0);
    reset = 1'b0;
    tick();

    // Streaming at one beat per cycle, including out-of-range codes
    saida_pronta   = 1'b1;
    entrada_valida = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seletor = vetores[i].sel;
      tick();
      check($sformatf("stream_dado[%0d]", i), saida, vetores[i].exp_dado);
      check($sformatf("stream_erro[%0d]", i), 32'(saida_erro), 32'(vetores[i].exp_erro));
      check($sformatf("stream_valida[%0d]", i), 32'(saida_valida), 32'd1);
      check($sformatf("stream_pronta[%0d]", i), 32'(entrada_pronta), 32'd1);
    end
    entrada_valida = 1'b0;
    tick();
    check("stream_drenado", 32'(saida_valida), 32'd0);
`ifdef MUX_CONTADOR_ERRO_EN
    check("contador_dois", 32'(contador_erro), 32'd2);
`endif

    // Backpressure: two beats held, second one lands in the skid buffer
    saida_pronta   = 1'b0;
    entrada_valida = 1'b1;
    seletor        = 3'd1;
    tick();
    check("bp_primeiro", saida, 32'hA1);
    seletor = 3'd2;
    tick();
    check("bp_pronta_baixo", 32'(entrada_pronta), 32'd0);
    check("bp_segura", saida, 32'hA1);
    entrada_valida = 1'b0;
    seletor        = 3'd3;
    tick();
    check("bp_estavel", saida, 32'hA1);
    check("bp_estavel_valida", 32'(saida_valida), 32'd1);
    saida_pronta = 1'b1;
    tick();
    check("bp_liberado", saida, 32'hA2);
    check("bp_pronta_volta", 32'(entrada_pronta), 32'd1);
    tick();
    check("bp_vazio", 32'(saida_valida), 32'd0);

    // Accept and consume on the same edge while full
    entrada_valida = 1'b1;
    seletor        = 3'd3;
    tick();
    check("sim_primeiro", saida, 32'hA3);
    seletor = 3'd4;
    tick();
    check("sim_novo", saida, 32'hA4);
    check("sim_pronta", 32'(entrada_pronta), 32'd1);
    check("sim_valida", 32'(saida_valida), 32'd1);
`ifdef MUX_CONTADOR_ERRO_EN
    seletor        = 3'd7;
    limpa_contador = 1'b1;
    tick();
    limpa_contador = 1'b0;
    check("limpa_vence", 32'(contador_erro), 32'd0);
    check("limpa_erro", 32'(saida_erro), 32'd1);
`endif

    // Reset asserted between edges while in SKID
    saida_pronta = 1'b0;
    seletor      = 3'd5;
    tick();
    check("rst_skid", 32'(entrada_pronta), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valida", 32'(saida_valida), 32'd0);
    check("rst_async_pronta", 32'(entrada_pronta), 32'd1);
    check("rst_async_saida", saida, 32'h0);
    #1;
    reset          = 1'b0;
    saida_pronta   = 1'b1;
    seletor        = 3'd0;
    tick();
    check("pos_rst_dado", saida, 32'hA0);
    check("pos_rst_valida", 32'(saida_valida), 32'd1);

`ifdef MUX_CONTADOR_ERRO_EN
    check("pos_rst_contador", 32'(contador_erro), 32'd0);
    seletor = 3'd6;
    for (int i = 0; i < 20; i++) tick();
    check("contador_satura", 32'(contador_erro), 32'hF);
`endif
    entrada_valida = 1'b0;
    tick();
    check("fim_vazio", 32'(saida_valida), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
